adder_mp_ctrl: RTL



---
 rtl/adder_mp_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/adder_mp_ctrl.sv
// adder_mp_ctrl
// Word-serial multi-precision add/subtract sequencer driving one shared
// BW_DATA-wide adder that lives beside this block at the parent level.
// Operand words arrive LSW first on a valid/ready stream. The carry is chained
// word to word through carry_r. Result words leave through a one-entry
// registered valid/ready slot.
//
// Subtraction is A + ~B + 1. The +1 comes from seeding carry_r with 1 at start,
// so the final carry-out reads 1 = no borrow.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for i_start; operand stream closed
// RUN   | accepting operand words, LSW first; carry chained through carry_r
// DRAIN | final word (o_s_last=1) held on o_s until the consumer takes it
module adder_mp_ctrl #(
    parameter int BW_DATA = 32,
    parameter int N_WORD  = 4,
    parameter int BW_CNT  = $clog2(N_WORD) + 1
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic               i_sub,
    input  logic               i_c_init,
    output logic               o_busy,
    input  logic               i_op_valid,
    output logic               o_op_ready,
    input  logic [BW_DATA-1:0] i_a,
    input  logic [BW_DATA-1:0] i_b,
    output logic [BW_DATA-1:0] o_add_a,
    output logic [BW_DATA-1:0] o_add_b,
    output logic               o_add_c,
    input  logic [BW_DATA-1:0] i_add_s,
    input  logic               i_add_c,
    output logic [BW_DATA-1:0] o_s,
    output logic               o_s_valid,
    output logic               o_s_last,
    input  logic               i_s_ready,
    output logic               o_c,
    output logic               o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [BW_CNT-1:0] LAST_CNT = BW_CNT'(N_WORD - 1);
    localparam logic [BW_CNT-1:0] CNT_ONE  = BW_CNT'(1);

    state_t              r_state;
    logic                r_sub;
    logic                r_carry;
    logic [BW_CNT-1:0]   r_cnt;
    logic [BW_DATA-1:0]  r_s;
    logic                r_s_valid;
    logic                r_s_last;
    logic                r_c;
    logic                r_done;

    logic                w_op_ready;
    logic                w_op_hs;
    logic                w_s_hs;
    logic                w_last_word;

    // Operand stream opens only in RUN, and only when the result slot is empty
    // or is being emptied this same cycle.
    assign w_op_ready  = (r_state == S_RUN) && (!r_s_valid || i_s_ready);
    assign w_op_hs     = i_op_valid && w_op_ready;
    assign w_s_hs      = r_s_valid && i_s_ready;
    assign w_last_word = (r_cnt == LAST_CNT);

    // Adder feed: B is inverted for subtract; the chained carry supplies the +1.
    assign o_add_a = i_a;
    assign o_add_b = r_sub ? ~i_b : i_b;
    assign o_add_c = r_carry;

    assign o_busy     = (r_state != S_IDLE);
    assign o_op_ready = w_op_ready;
    assign o_s        = r_s;
    assign o_s_valid  = r_s_valid;
    assign o_s_last   = r_s_last;
    assign o_c        = r_c;
    assign o_done     = r_done;

    // Sequencer: state, carry chain, word counter and the registered result slot.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= S_IDLE;
            r_sub     <= 1'b0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_s       <= '0;
            r_s_valid <= 1'b0;
            r_s_last  <= 1'b0;
            r_c       <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sub   <= i_sub;
                        r_carry <= i_sub ? 1'b1 : i_c_init;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_op_hs) begin
                        r_s       <= i_add_s;
                        r_s_valid <= 1'b1;
                        r_carry   <= i_add_c;
                        r_cnt     <= r_cnt + CNT_ONE;
                        if (w_last_word) begin
                            r_s_last <= 1'b1;
                            r_c      <= i_add_c;
                            r_state  <= S_DRAIN;
                        end
                    end else if (w_s_hs) begin
                        r_s_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_s_hs) begin
                        r_s_valid <= 1'b0;
                        r_s_last  <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
